calculadora_ctrl: RTL and testbench

Sequencer between the keypad scanner and the calculator datapath. It accepts one-cycle key events and enforces the entry order digit A -> operation -> digit B. It translates each accepted key into the exact command stream the calculator needs: selector key first, then the digit or operation key, each presented with ativo high for one clk. It then waits out the datapath latency, flags the result as ready, and handles clear, invalid keys and entry timeout.

---
 rtl/calculadora_ctrl_if.sv | 12 +
 rtl/calculadora_ctrl.sv | 99 +++++++++
 tb/tb_calculadora_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/calculadora_ctrl_if.sv
// calculadora_ctrl_if: keypad-event input and calculator-command output bundle of the sequencer
interface calculadora_ctrl_if;
  logic [4:0] tecla_in;
  logic       tecla_valida;
  logic       ativo;
  logic [4:0] tecla_out;
  logic       pronto;
  logic       erro;
  logic [3:0] estado;
  modport master (output tecla_in, tecla_valida, input ativo, tecla_out, pronto, erro, estado);
  modport slave  (input tecla_in, tecla_valida, output ativo, tecla_out, pronto, erro, estado);
endinterface

// File: rtl/calculadora_ctrl.sv
// calculadora_ctrl: orders keypad entry A -> op -> B and emits the calculator command stream
module calculadora_ctrl #(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int RESULT_WAIT = 2
) (
  input logic clk,
  input logic reset,
  calculadora_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int CW = $clog2(RESULT_WAIT + 1);
  typedef enum logic [3:0] {
    IDLE = 4'd0, SEL_A = 4'd1, WR_A = 4'd2, WAIT_OP = 4'd3, WR_OP = 4'd4,
    WAIT_B = 4'd5, SEL_B = 4'd6, WR_B = 4'd7, CALC = 4'd8, DONE = 4'd9
  } state_t;
  state_t state, nxt;
  logic [4:0] a, op, b, a_n, op_n, b_n, cmd, tecla_out;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] ccnt;
  logic ativo, pronto, erro, err, emit, tout, waiting;
  logic [4:0] key;
  logic v, is_dig, is_op, is_clr;
  assign key = bus.tecla_in;
  assign v = bus.tecla_valida;
  assign is_dig = key <= 5'd9;
  assign is_op = key >= 5'd10 && key <= 5'd12;
  assign is_clr = key == 5'd13;
  assign waiting = state == WAIT_OP || state == WAIT_B;
  assign tout = tcnt == TW'(TIMEOUT_CYC - 1);
  always_comb begin
    nxt = state;
    a_n = a;
    op_n = op;
    b_n = b;
    err = 1'b0;
    case (state)
      IDLE: if (v) begin
        if (is_dig) begin nxt = SEL_A; a_n = key; end
        else if (!is_clr) err = 1'b1;
      end
      SEL_A: nxt = WR_A;
      WR_A: nxt = WAIT_OP;
      WAIT_OP: if (v) begin
        if (is_op) begin nxt = WR_OP; op_n = key; end
        else if (is_clr) nxt = IDLE;
        else err = 1'b1;
      end else if (tout) begin nxt = IDLE; err = 1'b1; end
      WR_OP: nxt = WAIT_B;
      WAIT_B: if (v) begin
        if (is_dig) begin nxt = SEL_B; b_n = key; end
        else if (is_clr) nxt = IDLE;
        else err = 1'b1;
      end else if (tout) begin nxt = IDLE; err = 1'b1; end
      SEL_B: nxt = WR_B;
      WR_B: nxt = CALC;
      CALC: if (ccnt == CW'(RESULT_WAIT - 1)) nxt = DONE;
      DONE: if (v) begin
        if (is_dig) begin nxt = SEL_A; a_n = key; end
        else if (is_clr) nxt = IDLE;
        else err = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so a command lands one cycle after its key
  assign emit = nxt == SEL_A || nxt == WR_A || nxt == WR_OP || nxt == SEL_B || nxt == WR_B;
  assign cmd = nxt == SEL_A ? 5'd15 : nxt == WR_A ? a_n : nxt == WR_OP ? op_n :
               nxt == SEL_B ? 5'd14 : nxt == WR_B ? b_n : 5'd31;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= 5'd0;
      op <= 5'd0;
      b <= 5'd0;
      ativo <= 1'b0;
      tecla_out <= 5'd31;
      pronto <= 1'b0;
      erro <= 1'b0;
      tcnt <= '0;
      ccnt <= '0;
    end else begin
      state <= nxt;
      a <= a_n;
      op <= op_n;
      b <= b_n;
      ativo <= emit;
      tecla_out <= cmd;
      pronto <= nxt == DONE;
      erro <= err;
      tcnt <= (waiting && nxt == state && !v) ? tcnt + TW'(1) : '0;
      ccnt <= (state == CALC && nxt == CALC) ? ccnt + CW'(1) : '0;
    end
  end
  assign bus.ativo = ativo;
  assign bus.tecla_out = tecla_out;
  assign bus.pronto = pronto;
  assign bus.erro = erro;
  assign bus.estado = state;
endmodule

// File: tb/tb_calculadora_ctrl.sv
// tb_calculadora_ctrl: cycle-by-cycle vector table plus timeout and reset corner sequences
module tb_calculadora_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  calculadora_ctrl_if bus();
  calculadora_ctrl #(.TIMEOUT_CYC(8), .RESULT_WAIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] k;
    logic v;
    logic [3:0] st;
    logic a;
    logic [4:0] o;
    logic p;
    logic e;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic [4:0] k, input logic v, input logic [3:0] st, input logic a,
                     input logic [4:0] o, input logic p, input logic e);
    vec_t t;
    t.k = k; t.v = v; t.st = st; t.a = a; t.o = o; t.p = p; t.e = e;
    tbl.push_back(t);
  endtask
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  task automatic chk_all(input string tag, input logic [3:0] st, input logic a, input logic [4:0] o,
                         input logic p, input logic e);
    chk({tag, " estado"}, int'(bus.estado), int'(st));
    chk({tag, " ativo"}, int'(bus.ativo), int'(a));
    chk({tag, " tecla_out"}, int'(bus.tecla_out), int'(o));
    chk({tag, " pronto"}, int'(bus.pronto), int'(p));
    chk({tag, " erro"}, int'(bus.erro), int'(e));
  endtask
  task automatic step(input logic [4:0] k, input logic v);
    bus.tecla_in = k;
    bus.tecla_valida = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.tecla_in = 5'd31;
    bus.tecla_valida = 1'b0;
    // 3 A 4 -> 15,3,10,14,4 then DONE after two CALC cycles
    add(3, 1, 1, 1, 15, 0, 0); add(31, 0, 2, 1, 3, 0, 0); add(31, 0, 3, 0, 31, 0, 0);
    add(10, 1, 4, 1, 10, 0, 0); add(31, 0, 5, 0, 31, 0, 0); add(31, 0, 5, 0, 31, 0, 0);
    add(4, 1, 6, 1, 14, 0, 0); add(31, 0, 7, 1, 4, 0, 0); add(31, 0, 8, 0, 31, 0, 0);
    add(31, 0, 8, 0, 31, 0, 0); add(31, 0, 9, 0, 31, 1, 0);
    // 2 B 9 from DONE, key 5 ignored during CALC
    add(2, 1, 1, 1, 15, 0, 0); add(31, 0, 2, 1, 2, 0, 0); add(31, 0, 3, 0, 31, 0, 0);
    add(11, 1, 4, 1, 11, 0, 0); add(31, 0, 5, 0, 31, 0, 0); add(31, 0, 5, 0, 31, 0, 0);
    add(9, 1, 6, 1, 14, 0, 0); add(31, 0, 7, 1, 9, 0, 0); add(31, 0, 8, 0, 31, 0, 0);
    add(5, 1, 8, 0, 31, 0, 0); add(31, 0, 9, 0, 31, 1, 0);
    // op key in DONE rejected, D clears to IDLE
    add(10, 1, 9, 0, 31, 1, 1); add(31, 0, 9, 0, 31, 1, 0); add(13, 1, 0, 0, 31, 0, 0);
    // A in IDLE rejected, D in IDLE silent, 5 then 6 rejected in WAIT_OP, then C 3
    add(10, 1, 0, 0, 31, 0, 1); add(31, 0, 0, 0, 31, 0, 0); add(13, 1, 0, 0, 31, 0, 0);
    add(5, 1, 1, 1, 15, 0, 0); add(31, 0, 2, 1, 5, 0, 0); add(31, 0, 3, 0, 31, 0, 0);
    add(6, 1, 3, 0, 31, 0, 1); add(31, 0, 3, 0, 31, 0, 0); add(12, 1, 4, 1, 12, 0, 0);
    add(31, 0, 5, 0, 31, 0, 0); add(3, 1, 6, 1, 14, 0, 0); add(31, 0, 7, 1, 3, 0, 0);
    add(31, 0, 8, 0, 31, 0, 0); add(31, 0, 8, 0, 31, 0, 0); add(31, 0, 9, 0, 31, 1, 0);
    // 7 in DONE drops pronto, then D in WAIT_B aborts silently
    add(7, 1, 1, 1, 15, 0, 0); add(31, 0, 2, 1, 7, 0, 0); add(31, 0, 3, 0, 31, 0, 0);
    add(11, 1, 4, 1, 11, 0, 0); add(31, 0, 5, 0, 31, 0, 0); add(13, 1, 0, 0, 31, 0, 0);
    add(31, 0, 0, 0, 31, 0, 0);
    step(31, 0);
    step(31, 0);
    chk_all("reset", 0, 0, 31, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].k, tbl[i].v);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].a, tbl[i].o, tbl[i].p, tbl[i].e);
    end
    // timeout: erro and IDLE exactly 8 cycles after entering WAIT_OP
    step(5, 1);
    step(31, 0);
    step(31, 0);
    chk("to enter estado", int'(bus.estado), 3);
    for (int k = 1; k <= 7; k++) begin
      step(31, 0);
      chk($sformatf("to wait%0d estado", k), int'(bus.estado), 3);
      chk($sformatf("to wait%0d erro", k), int'(bus.erro), 0);
    end
    step(31, 0);
    chk_all("to fire", 0, 0, 31, 0, 1);
    step(31, 0);
    chk_all("to after", 0, 0, 31, 0, 0);
    // key on the firing cycle cancels the timeout
    step(6, 1);
    step(31, 0);
    step(31, 0);
    for (int k = 1; k <= 7; k++) step(31, 0);
    chk("cancel pre estado", int'(bus.estado), 3);
    step(10, 1);
    chk_all("cancel key", 4, 1, 10, 0, 0);
    step(31, 0);
    chk("cancel wait_b", int'(bus.estado), 5);
    // reset beats a simultaneous digit in WAIT_B
    reset = 1'b1;
    step(4, 1);
    chk_all("rst key", 0, 0, 31, 0, 0);
    reset = 1'b0;
    step(31, 0);
    chk_all("rst after", 0, 0, 31, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
